regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter.sv | 137 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port sequencer: zero-clear walk after reset or clear_req, then one writeback grant per cycle.
// Define WB_ROUND_ROBIN_EN for round-robin arbitration; the default build uses fixed priority (index 0 highest).
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_REGS      = 32,
  parameter int NUM_REQ       = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear_req,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_dest,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             rg_wrt_en,
  output logic [ADDRESS_WIDTH-1:0]         rg_wrt_dest,
  output logic [DATA_WIDTH-1:0]            rg_wrt_data,
  output logic                             init_done
);

  typedef enum logic {
    CLEAR = 1'b0,
    ARB   = 1'b1
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_REG = ADDRESS_WIDTH'(NUM_REGS - 1);

  state_t                     r_state;
  state_t                     w_state_next;
  logic [ADDRESS_WIDTH-1:0]   r_clr_cnt;
  logic                       r_wrt_en;
  logic [ADDRESS_WIDTH-1:0]   r_wrt_dest;
  logic [DATA_WIDTH-1:0]      r_wrt_data;

  logic                       w_found;
  logic                       w_xfer;
  logic [NUM_REQ-1:0]         w_ready;
  logic [ADDRESS_WIDTH-1:0]   w_sel_dest;
  logic [DATA_WIDTH-1:0]      w_sel_data;

`ifdef WB_ROUND_ROBIN_EN
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  logic [IDX_W-1:0]           r_rr_ptr;
  logic [IDX_W-1:0]           w_rr_next;

  // Rotating search starting at r_rr_ptr; the first valid requester found wins.
  always_comb begin
    int v_idx;
    v_idx      = 0;
    w_found    = 1'b0;
    w_ready    = '0;
    w_sel_dest = '0;
    w_sel_data = '0;
    w_rr_next  = r_rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_idx = int'(r_rr_ptr) + k;
      if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
      if (!w_found && req_valid[v_idx]) begin
        w_found    = 1'b1;
        w_ready[v_idx] = 1'b1;
        w_sel_dest = req_dest[v_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        w_sel_data = req_data[v_idx*DATA_WIDTH +: DATA_WIDTH];
        w_rr_next  = (v_idx == NUM_REQ - 1) ? '0 : IDX_W'(v_idx + 1);
      end
    end
  end
`else
  // Fixed priority: the lowest valid index wins.
  always_comb begin
    w_found    = 1'b0;
    w_ready    = '0;
    w_sel_dest = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid[i]) begin
        w_found    = 1'b1;
        w_ready[i] = 1'b1;
        w_sel_dest = req_dest[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        w_sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end
`endif

  // Grants are only visible in ARB, out of reset, and when no clear is being requested.
  assign req_ready = (!rst && r_state == ARB && !clear_req) ? w_ready : '0;
  assign w_xfer    = (r_state == ARB) && !clear_req && w_found;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      CLEAR:   if (r_clr_cnt == LAST_REG) w_state_next = ARB;
      ARB:     if (clear_req) w_state_next = CLEAR;
      default: w_state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= CLEAR;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr_cnt  <= '0;
      r_wrt_en   <= 1'b0;
      r_wrt_dest <= '0;
      r_wrt_data <= '0;
    end else if (r_state == CLEAR) begin
      r_wrt_en   <= 1'b1;
      r_wrt_dest <= r_clr_cnt;
      r_wrt_data <= '0;
      r_clr_cnt  <= (r_clr_cnt == LAST_REG) ? '0 : r_clr_cnt + 1'b1;
    end else if (w_xfer) begin
      // x0 completes the handshake but never reaches the register file.
      r_wrt_en   <= (w_sel_dest != '0);
      r_wrt_dest <= w_sel_dest;
      r_wrt_data <= w_sel_data;
    end else begin
      r_wrt_en   <= 1'b0;
    end
  end

`ifdef WB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst)         r_rr_ptr <= '0;
    else if (w_xfer) r_rr_ptr <= w_rr_next;
  end
`endif

  assign rg_wrt_en   = r_wrt_en;
  assign rg_wrt_dest = r_wrt_dest;
  assign rg_wrt_data = r_wrt_data;
  assign init_done   = (r_state == ARB);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: clear walk, grants, x0 drop, clear_req re-walk, reset mid-walk.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        clear_req;
  logic [2:0]  req_valid;
  logic [14:0] req_dest;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        rg_wrt_en;
  logic [4:0]  rg_wrt_dest;
  logic [31:0] rg_wrt_data;
  logic        init_done;

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(5), .NUM_REGS(32), .NUM_REQ(3)
  ) dut (
    .clk(clk), .rst(rst), .clear_req(clear_req),
    .req_valid(req_valid), .req_dest(req_dest), .req_data(req_data),
    .req_ready(req_ready), .rg_wrt_en(rg_wrt_en), .rg_wrt_dest(rg_wrt_dest),
    .rg_wrt_data(rg_wrt_data), .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] v, input logic [4:0] d0, input logic [4:0] d1,
                               input logic [4:0] d2, input logic [31:0] a0, input logic [31:0] a1,
                               input logic [31:0] a2, input logic clr);
    req_valid = v;
    req_dest  = {d2, d1, d0};
    req_data  = {a2, a1, a0};
    clear_req = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk checks: one edge per register, init_done rising only after dest=31.
  task automatic checkWalk(input string tag, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      checkOutput({tag, "_ready"}, 64'(req_ready), 64'd0);
      tick();
      checkOutput({tag, "_en"}, 64'(rg_wrt_en), 64'd1);
      checkOutput({tag, "_dest"}, 64'(rg_wrt_dest), 64'(i));
      checkOutput({tag, "_data"}, 64'(rg_wrt_data), 64'd0);
      checkOutput({tag, "_done"}, 64'(init_done), (i == 31) ? 64'd1 : 64'd0);
    end
  endtask

  initial begin
    int expIdx;
    logic [4:0] dests [3];
    logic [31:0] datas [3];
    dests[0] = 5'd10; dests[1] = 5'd11; dests[2] = 5'd12;
    datas[0] = 32'hA0A0_0000; datas[1] = 32'hB1B1_1111; datas[2] = 32'hC2C2_2222;

    // Reset
    rst = 1'b1;
    applyStimulus(3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, 1'b0);
    tick();
    checkOutput("rst_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_en", 64'(rg_wrt_en), 64'd0);
    checkOutput("rst_dest", 64'(rg_wrt_dest), 64'd0);
    checkOutput("rst_data", 64'(rg_wrt_data), 64'd0);
    checkOutput("rst_done", 64'(init_done), 64'd0);
    rst = 1'b0;

    // Initial clear walk with requests pending: none may be granted
    checkWalk("walk1", 0, 31);

    // Single grant and one-cycle latency
    applyStimulus(3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0);
    #1 checkOutput("t2_ready", 64'(req_ready), 64'b001);
    tick();
    checkOutput("t2_en", 64'(rg_wrt_en), 64'd1);
    checkOutput("t2_dest", 64'(rg_wrt_dest), 64'd5);
    checkOutput("t2_data", 64'(rg_wrt_data), 64'hDEADBEEF);
    applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    #1 checkOutput("t2_idle_ready", 64'(req_ready), 64'd0);
    tick();
    checkOutput("t2_en_drop", 64'(rg_wrt_en), 64'd0);

    // All three requesters held for six cycles
    applyStimulus(3'b111, dests[0], dests[1], dests[2], datas[0], datas[1], datas[2], 1'b0);
    for (int c = 0; c < 6; c++) begin
`ifdef WB_ROUND_ROBIN_EN
      expIdx = (1 + c) % 3;
`else
      expIdx = 0;
`endif
      #1 checkOutput("t3_ready", 64'(req_ready), 64'(3'b001 << expIdx));
      tick();
      checkOutput("t3_dest", 64'(rg_wrt_dest), 64'(dests[expIdx]));
      checkOutput("t3_data", 64'(rg_wrt_data), 64'(datas[expIdx]));
      checkOutput("t3_en", 64'(rg_wrt_en), 64'd1);
    end
    applyStimulus(3'b110, dests[0], dests[1], dests[2], datas[0], datas[1], datas[2], 1'b0);
    #1 checkOutput("t3_drop0_ready", 64'(req_ready), 64'b010);
    tick();
    checkOutput("t3_drop0_dest", 64'(rg_wrt_dest), 64'd11);

    // x0 write: handshake completes, no write enable
    applyStimulus(3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'h1234, 32'h0, 1'b0);
    #1 checkOutput("t4_ready", 64'(req_ready), 64'b010);
    tick();
    checkOutput("t4_en", 64'(rg_wrt_en), 64'd0);
    checkOutput("t4_dest", 64'(rg_wrt_dest), 64'd0);
    applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);

    // clear_req while req2 is waiting
    applyStimulus(3'b100, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h77, 1'b1);
    #1 checkOutput("t5_ready", 64'(req_ready), 64'd0);
    checkOutput("t5_done_pre", 64'(init_done), 64'd1);
    tick();
    clear_req = 1'b0;
    checkOutput("t5_en", 64'(rg_wrt_en), 64'd0);
    checkOutput("t5_done", 64'(init_done), 64'd0);
    checkWalk("walk2", 0, 31);
    checkOutput("t5_ready_arb", 64'(req_ready), 64'b100);
    tick();
    checkOutput("t5_en_acc", 64'(rg_wrt_en), 64'd1);
    checkOutput("t5_dest_acc", 64'(rg_wrt_dest), 64'd7);
    checkOutput("t5_data_acc", 64'(rg_wrt_data), 64'h77);

    // Reset at clr_cnt=17 restarts the walk from register 0
    applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1);
    tick();
    clear_req = 1'b0;
    checkWalk("walk3", 0, 16);
    rst = 1'b1;
    applyStimulus(3'b001, 5'd9, 5'd0, 5'd0, 32'h99, 32'h0, 32'h0, 1'b0);
    #1 checkOutput("t6_ready_rst", 64'(req_ready), 64'd0);
    tick();
    checkOutput("t6_en", 64'(rg_wrt_en), 64'd0);
    checkOutput("t6_dest", 64'(rg_wrt_dest), 64'd0);
    checkOutput("t6_data", 64'(rg_wrt_data), 64'd0);
    checkOutput("t6_done", 64'(init_done), 64'd0);
    rst = 1'b0;
    checkWalk("walk4", 0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
